// File: rtl/sprite_line_engine.sv
// sprite_line_engine: per-scanline sprite slots with X countdown, pixel shift-out and
// lowest-index-wins opaque resolve into registered mixer outputs.
module sprite_line_engine #(
  parameter int NUM_SLOTS = 8,
  parameter int BPP = 2,
  parameter int PAL_BITS = 2,
  parameter int XW = 8,
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce,
  input  logic                enable,
  input  logic                clear,
  input  logic                load,
  input  logic [SW-1:0]       load_slot,
  input  logic [BPP*8-1:0]    load_pat,
  input  logic [XW-1:0]       load_x,
  input  logic [PAL_BITS-1:0] load_pal,
  input  logic                load_prio,
  input  logic                load_hflip,
  output logic [BPP-1:0]      pix_color,
  output logic [PAL_BITS-1:0] pix_pal,
  output logic                pix_prio,
  output logic [SW-1:0]       pix_slot,
  output logic                pix_hit0,
  output logic                busy
);
  logic [NUM_SLOTS-1:0] valid_q, valid_d, prio_q, prio_d;
  logic [XW-1:0] x_q [NUM_SLOTS];
  logic [XW-1:0] x_d [NUM_SLOTS];
  logic [3:0] rem_q [NUM_SLOTS];
  logic [3:0] rem_d [NUM_SLOTS];
  logic [BPP-1:0][7:0] pl_q [NUM_SLOTS];
  logic [BPP-1:0][7:0] pl_d [NUM_SLOTS];
  logic [PAL_BITS-1:0] pal_q [NUM_SLOTS];
  logic [PAL_BITS-1:0] pal_d [NUM_SLOTS];
  logic [BPP-1:0] col_q, col_c;
  logic [PAL_BITS-1:0] opal_q, opal_c;
  logic oprio_q, oprio_c, hit0_q, hit0_c, busy_c;
  logic [SW-1:0] slot_q, slot_c;

  function automatic logic [BPP-1:0] col_of(input logic [BPP-1:0][7:0] pl);
    logic [BPP-1:0] c;
    for (int p = 0; p < BPP; p++) c[p] = pl[p][0];
    return c;
  endfunction

  function automatic logic active(input logic v, input logic [XW-1:0] x, input logic [3:0] r);
    return v && x == '0 && r != '0;
  endfunction

  // Advance first, then clear, then load, so load/clear override the dot step.
  always_comb begin
    valid_d = valid_q;
    prio_d = prio_q;
    x_d = x_q;
    rem_d = rem_q;
    pl_d = pl_q;
    pal_d = pal_q;
    if (ce) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (enable && valid_q[s]) begin
          if (x_q[s] != '0) x_d[s] = x_q[s] - XW'(1);
          else if (rem_q[s] != '0) begin
            rem_d[s] = rem_q[s] - 4'd1;
            for (int p = 0; p < BPP; p++) pl_d[s][p] = pl_q[s][p] >> 1;
          end
        end
        if (clear) begin
          valid_d[s] = 1'b0;
          rem_d[s] = '0;
        end
        if (load && load_slot == SW'(s)) begin
          valid_d[s] = 1'b1;
          x_d[s] = load_x;
          rem_d[s] = 4'd8;
          pal_d[s] = load_pal;
          prio_d[s] = load_prio;
          for (int p = 0; p < BPP; p++)
            for (int i = 0; i < 8; i++)
              pl_d[s][p][i] = load_hflip ? load_pat[p*8+7-i] : load_pat[p*8+i];
        end
      end
    end
  end

  // Descending scan so the lowest-index opaque slot is the last writer.
  always_comb begin
    col_c = '0;
    opal_c = '0;
    oprio_c = 1'b0;
    slot_c = '0;
    busy_c = 1'b0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (active(valid_q[s], x_q[s], rem_q[s]) && col_of(pl_q[s]) != '0) begin
        col_c = col_of(pl_q[s]);
        opal_c = pal_q[s];
        oprio_c = prio_q[s];
        slot_c = SW'(s);
      end
      busy_c = busy_c | (valid_q[s] && rem_q[s] != '0);
    end
    hit0_c = active(valid_q[0], x_q[0], rem_q[0]) && col_of(pl_q[0]) != '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      prio_q <= '0;
      x_q <= '{default: '0};
      rem_q <= '{default: '0};
      pl_q <= '{default: '0};
      pal_q <= '{default: '0};
      col_q <= '0;
      opal_q <= '0;
      oprio_q <= 1'b0;
      slot_q <= '0;
      hit0_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      prio_q <= prio_d;
      x_q <= x_d;
      rem_q <= rem_d;
      pl_q <= pl_d;
      pal_q <= pal_d;
      if (ce && enable) begin
        col_q <= col_c;
        opal_q <= opal_c;
        oprio_q <= oprio_c;
        slot_q <= slot_c;
        hit0_q <= hit0_c;
      end
    end
  end

  assign pix_color = col_q;
  assign pix_pal = opal_q;
  assign pix_prio = oprio_q;
  assign pix_slot = slot_q;
  assign pix_hit0 = hit0_q;
  assign busy = busy_c;
endmodule

// File: tb/tb_sprite_line_engine.sv
// tb_sprite_line_engine: directed spec scenarios plus random traffic, checked every
// cycle against a pixel-list model of the sprite slots.
module tb_sprite_line_engine;
  localparam int NS = 8;
  logic clk = 0, reset = 0, ce = 0, enable = 0, clear = 0, load = 0;
  logic [2:0] load_slot = 0;
  logic [15:0] load_pat = 0;
  logic [7:0] load_x = 0;
  logic [1:0] load_pal = 0;
  logic load_prio = 0, load_hflip = 0;
  logic [1:0] pix_color, pix_pal;
  logic pix_prio, pix_hit0, busy;
  logic [2:0] pix_slot;
  int total = 0, bad = 0;

  sprite_line_engine dut (
    .clk(clk), .reset(reset), .ce(ce), .enable(enable), .clear(clear), .load(load),
    .load_slot(load_slot), .load_pat(load_pat), .load_x(load_x), .load_pal(load_pal),
    .load_prio(load_prio), .load_hflip(load_hflip), .pix_color(pix_color),
    .pix_pal(pix_pal), .pix_prio(pix_prio), .pix_slot(pix_slot), .pix_hit0(pix_hit0),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: each slot is a wait count plus a list of 8 colours and a read index k.
  int m_valid [NS], m_x [NS], m_k [NS], m_pal [NS], m_prio [NS];
  int m_col [NS][8];
  int e_color = 0, e_pal = 0, e_prio = 0, e_slot = 0, e_hit0 = 0, e_busy = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      for (int s = 0; s < NS; s++) begin
        m_valid[s] = 0; m_x[s] = 0; m_k[s] = 8;
      end
      e_color = 0; e_pal = 0; e_prio = 0; e_slot = 0; e_hit0 = 0;
    end else if (ce) begin
      if (enable) begin
        int won = 0;
        e_color = 0; e_pal = 0; e_prio = 0; e_slot = 0; e_hit0 = 0;
        for (int s = 0; s < NS; s++) begin
          if (m_valid[s] != 0 && m_x[s] == 0 && m_k[s] < 8 && m_col[s][m_k[s]] != 0) begin
            if (s == 0) e_hit0 = 1;
            if (won == 0) begin
              won = 1; e_color = m_col[s][m_k[s]]; e_pal = m_pal[s];
              e_prio = m_prio[s]; e_slot = s;
            end
          end
        end
        for (int s = 0; s < NS; s++)
          if (m_valid[s] != 0) begin
            if (m_x[s] > 0) m_x[s]--;
            else if (m_k[s] < 8) m_k[s]++;
          end
      end
      if (clear)
        for (int s = 0; s < NS; s++) begin
          m_valid[s] = 0; m_k[s] = 8;
        end
      if (load) begin
        int s = int'(load_slot);
        m_valid[s] = 1; m_x[s] = int'(load_x); m_k[s] = 0;
        m_pal[s] = int'(load_pal); m_prio[s] = int'(load_prio);
        for (int j = 0; j < 8; j++) begin
          int i = load_hflip ? 7 - j : j;
          m_col[s][j] = int'(load_pat[i]) + 2 * int'(load_pat[8+i]);
        end
      end
    end
    e_busy = 0;
    for (int s = 0; s < NS; s++) if (m_valid[s] != 0 && m_k[s] < 8) e_busy = 1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    chk("color", int'(pix_color), e_color);
    chk("pal", int'(pix_pal), e_pal);
    chk("prio", int'(pix_prio), e_prio);
    chk("slot", int'(pix_slot), e_slot);
    chk("hit0", int'(pix_hit0), e_hit0);
    chk("busy", int'(busy), e_busy);
  end

  task automatic idle();
    ce = 1; enable = 0; clear = 0; load = 0; reset = 0;
  endtask

  task automatic do_load(input int s, input int p0, input int p1, input int x, input int pal,
                         input int prio, input int hf);
    idle();
    load = 1; load_slot = 3'(s); load_pat = {8'(p1), 8'(p0)}; load_x = 8'(x);
    load_pal = 2'(pal); load_prio = 1'(prio); load_hflip = 1'(hf);
    tick();
    load = 0;
  endtask

  task automatic adv();
    idle();
    enable = 1;
    tick();
    enable = 0;
  endtask

  int seq1 [12] = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
  int seq2 [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1};

  initial begin
    logic [1:0] hold_c;
    logic [2:0] hold_s;
    for (int s = 0; s < NS; s++) begin
      m_valid[s] = 0; m_x[s] = 0; m_k[s] = 8; m_pal[s] = 0; m_prio[s] = 0;
      for (int j = 0; j < 8; j++) m_col[s][j] = 0;
    end
    reset = 1; ce = 1;
    tick();
    chk("reset_color", int'(pix_color), 0);
    chk("reset_busy", int'(busy), 0);
    // Scenario 1: plain pattern, x=2.
    do_load(3, 8'b0000_0101, 0, 2, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      adv();
      chk("s1_color", int'(pix_color), seq1[i]);
      if (seq1[i] != 0) chk("s1_pal", int'(pix_pal), 1);
      if (i == 8) chk("s1_busy9", int'(busy), 1);
      if (i == 9) chk("s1_busy10", int'(busy), 0);
    end
    // Scenario 2: mirrored.
    do_load(3, 8'b0000_0101, 0, 2, 1, 0, 1);
    for (int i = 0; i < 10; i++) begin
      adv();
      chk("s2_color", int'(pix_color), seq2[i]);
    end
    // Scenario 3: overlap, lower index wins.
    do_load(1, 8'hFF, 8'h00, 0, 2, 1, 0);
    do_load(5, 8'hFF, 8'hFF, 0, 3, 0, 0);
    for (int i = 0; i < 8; i++) begin
      adv();
      chk("s3_slot", int'(pix_slot), 1);
      chk("s3_color", int'(pix_color), 1);
    end
    do_load(1, 0, 0, 0, 2, 1, 0);
    do_load(5, 8'hFF, 8'hFF, 0, 3, 0, 0);
    adv();
    chk("s3b_slot", int'(pix_slot), 5);
    chk("s3b_color", int'(pix_color), 3);
    // Scenario 4: slot0 transparent, then opaque.
    do_load(0, 0, 0, 0, 0, 0, 0);
    do_load(2, 8'hFF, 0, 0, 1, 0, 0);
    adv();
    chk("s4_hit0", int'(pix_hit0), 0);
    chk("s4_slot", int'(pix_slot), 2);
    do_load(0, 8'h00, 8'hFF, 0, 0, 0, 0);
    adv();
    chk("s4b_hit0", int'(pix_hit0), 1);
    chk("s4b_slot", int'(pix_slot), 0);
    // Scenario 5: clear and load together.
    idle(); clear = 1; load = 1; load_slot = 2; load_pat = 16'h0001; load_x = 0;
    load_pal = 0; load_prio = 0; load_hflip = 0;
    tick();
    adv();
    chk("s5_color", int'(pix_color), 1);
    chk("s5_slot", int'(pix_slot), 2);
    chk("s5_hit0", int'(pix_hit0), 0);
    // Scenario 6: ce hold mid-sprite, then reset.
    do_load(4, 8'hAA, 8'hCC, 0, 2, 1, 0);
    adv(); adv();
    hold_c = pix_color; hold_s = pix_slot;
    idle(); ce = 0; enable = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("s6_hold_color", int'(pix_color), int'(hold_c));
    chk("s6_hold_slot", int'(pix_slot), int'(hold_s));
    chk("s6_hold_busy", int'(busy), 1);
    idle(); reset = 1; enable = 1; load = 1;
    tick();
    chk("s6_rst_color", int'(pix_color), 0);
    chk("s6_rst_busy", int'(busy), 0);
    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom % 150) == 0;
      ce = ($urandom % 8) != 0;
      enable = ($urandom % 4) != 0;
      clear = ($urandom % 40) == 0;
      load = ($urandom % 5) == 0;
      load_slot = 3'($urandom);
      load_pat = 16'($urandom);
      load_x = 8'($urandom % 12);
      load_pal = 2'($urandom);
      load_prio = 1'($urandom);
      load_hflip = 1'($urandom);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
